// File: rtl/shwr_integral_multi_if.sv
// Trigger/sample bus between the shower trigger, the integrator and the event-readout registers.
interface shwr_integral_multi_if #(
  parameter int unsigned NCH        = 3,
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned EXTRA_BITS = 2,
  parameter int unsigned AREA_W     = 19
);
  logic [NCH*ADC_W-1:0]              ADC;
  logic                              TRIGGERED;
  logic [11:0]                       WINDOW_LEN;
  logic [NCH*AREA_W-1:0]             INTEGRAL;
  logic [NCH*(ADC_W+EXTRA_BITS)-1:0] BASELINE;
  logic [NCH*ADC_W-1:0]              PEAK;
  logic [NCH-1:0]                    SATURATED;
  logic                              BUSY;
  logic                              DONE;

  modport master (
    output ADC, TRIGGERED, WINDOW_LEN,
    input  INTEGRAL, BASELINE, PEAK, SATURATED, BUSY, DONE
  );

  modport slave (
    input  ADC, TRIGGERED, WINDOW_LEN,
    output INTEGRAL, BASELINE, PEAK, SATURATED, BUSY, DONE
  );
endinterface

// File: rtl/shwr_integral_multi.sv
// Multi-channel shower integral: idle baseline tracking, triggered window integration,
// per-channel integral / peak / saturation capture with a DONE strobe.
module shwr_integral_multi #(
  parameter int unsigned NCH        = 3,
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned FRAC_W     = 6,
  parameter int unsigned EXTRA_BITS = 2,
  parameter int unsigned AREA_W     = 19,
  parameter int unsigned PRE_DLY    = 4,
  parameter int unsigned SAT_LEVEL  = 4095,
  parameter int unsigned BL_INIT    = 250
) (
  input logic                  CLK120,
  input logic                  RESET,
  shwr_integral_multi_if.slave bus
);
  localparam int unsigned LB_W  = ADC_W + FRAC_W;
  localparam int unsigned LBX_W = LB_W + 1;
  localparam int unsigned ACC_W = ADC_W + FRAC_W + 13;
  localparam int unsigned BL_W  = ADC_W + EXTRA_BITS;
  localparam int unsigned RB_W  = ADC_W + 1;
  localparam int unsigned CNT_W = 12;
  localparam int unsigned HALF  = 1 << (FRAC_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_INTEG, S_HOLD} state_t;

  state_t                  state, state_nxt;
  logic [ADC_W-1:0]        dly     [NCH][PRE_DLY+1];
  logic [ADC_W-1:0]        adcd    [NCH];
  logic [LB_W-1:0]         adcl    [NCH];
  logic [LB_W-1:0]         lb      [NCH];
  logic [LB_W-1:0]         fb      [NCH];
  logic [RB_W-1:0]         rb      [NCH];
  logic signed [ACC_W-1:0] acc     [NCH];
  logic signed [ACC_W-1:0] acc_nxt [NCH];
  logic [ADC_W-1:0]        mx      [NCH];
  logic [ADC_W-1:0]        mx_nxt  [NCH];
  logic [NCH-1:0]          sat, sat_nxt;
  logic [CNT_W-1:0]        cnt, win_last;
  logic                    trig_prev, accept, win_end;

  // Step the fixed-point baseline one LSB towards the sample, saturating at both ends.
  function automatic logic [LB_W-1:0] track(input logic [LB_W-1:0] lbv, input logic [LB_W-1:0] x);
    if (x > lbv && lbv != '1)      return lbv + LB_W'(1);
    else if (x < lbv && lbv != '0) return lbv - LB_W'(1);
    else                           return lbv;
  endfunction

  function automatic logic [AREA_W-1:0] clamp_area(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_W;
    if (s[ACC_W-1])              return '0;
    else if (|s[ACC_W-2:AREA_W]) return '1;
    else                         return s[AREA_W-1:0];
  endfunction

  function automatic logic [ADC_W-1:0] peak_of(input logic [ADC_W-1:0] m, input logic [RB_W-1:0] r);
    if (RB_W'(m) > r) return ADC_W'(RB_W'(m) - r);
    else              return '0;
  endfunction

  always_ff @(posedge CLK120 or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    win_end   = 1'b0;
    unique case (state)
      S_IDLE:  if (bus.TRIGGERED && !trig_prev) begin
                 accept    = 1'b1;
                 state_nxt = S_INTEG;
               end
      S_INTEG: if (cnt == win_last) begin
                 win_end   = 1'b1;
                 state_nxt = S_HOLD;
               end
      S_HOLD:  if (!bus.TRIGGERED) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-channel next-sample arithmetic on the delayed sample.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      adcd[c]    = dly[c][PRE_DLY];
      adcl[c]    = {adcd[c], {FRAC_W{1'b0}}};
      acc_nxt[c] = acc[c] + $signed(ACC_W'(adcl[c])) - $signed(ACC_W'(fb[c]));
      mx_nxt[c]  = (adcd[c] > mx[c]) ? adcd[c] : mx[c];
      sat_nxt[c] = sat[c] | (adcd[c] >= ADC_W'(SAT_LEVEL));
    end
  end

  always_ff @(posedge CLK120 or posedge RESET) begin
    if (RESET) begin
      trig_prev     <= 1'b1;
      cnt           <= '0;
      win_last      <= '0;
      sat           <= '0;
      bus.BUSY      <= 1'b0;
      bus.DONE      <= 1'b0;
      bus.INTEGRAL  <= '0;
      bus.PEAK      <= '0;
      bus.SATURATED <= '0;
      for (int c = 0; c < NCH; c++) begin
        for (int i = 0; i <= PRE_DLY; i++) dly[c][i] <= '0;
        lb[c]  <= LB_W'(BL_INIT << FRAC_W);
        fb[c]  <= LB_W'(BL_INIT << FRAC_W);
        rb[c]  <= RB_W'(BL_INIT);
        acc[c] <= '0;
        mx[c]  <= '0;
        bus.BASELINE[c*BL_W +: BL_W] <= BL_W'(BL_INIT << EXTRA_BITS);
      end
    end else begin
      trig_prev <= bus.TRIGGERED;
      bus.BUSY  <= (state_nxt != S_IDLE);
      bus.DONE  <= win_end;

      // Window length is latched at acceptance; zero means a single sample.
      if (accept) begin
        cnt      <= '0;
        win_last <= (bus.WINDOW_LEN == 12'd0) ? '0 : CNT_W'(bus.WINDOW_LEN - 12'd1);
      end else if (state == S_INTEG) begin
        cnt <= cnt + CNT_W'(1);
      end

      for (int c = 0; c < NCH; c++) begin
        dly[c][0] <= bus.ADC[c*ADC_W +: ADC_W];
        for (int i = 1; i <= PRE_DLY; i++) dly[c][i] <= dly[c][i-1];

        if (state == S_IDLE) begin
          lb[c] <= track(lb[c], adcl[c]);
          bus.BASELINE[c*BL_W +: BL_W] <= BL_W'(lb[c] >> (FRAC_W - EXTRA_BITS));
        end

        if (accept) begin
          fb[c]  <= lb[c];
          rb[c]  <= RB_W'((LBX_W'(lb[c]) + LBX_W'(HALF)) >> FRAC_W);
          acc[c] <= '0;
          mx[c]  <= '0;
          sat[c] <= 1'b0;
        end else if (state == S_INTEG) begin
          acc[c] <= acc_nxt[c];
          mx[c]  <= mx_nxt[c];
          sat[c] <= sat_nxt[c];
        end

        if (win_end) begin
          bus.INTEGRAL[c*AREA_W +: AREA_W] <= clamp_area(acc_nxt[c]);
          bus.PEAK[c*ADC_W +: ADC_W]       <= peak_of(mx_nxt[c], rb[c]);
          bus.SATURATED[c]                 <= sat_nxt[c];
        end
      end
    end
  end
endmodule

// File: tb/tb_shwr_integral_multi.sv
// Bench for shwr_integral_multi: directed scenarios plus random traffic against a
// sample-history reference model of baseline tracking and window integration.
module tb_shwr_integral_multi;
  localparam int NCH        = 3;
  localparam int ADC_W      = 12;
  localparam int FRAC_W     = 6;
  localparam int EXTRA_BITS = 2;
  localparam int AREA_W     = 19;
  localparam int PD         = 4;
  localparam int SAT_LEVEL  = 4095;
  localparam int BL_INIT    = 250;
  localparam int BL_W       = ADC_W + EXTRA_BITS;
  localparam int HMAX       = 16384;
  localparam int LB_MAX     = (1 << (ADC_W + FRAC_W)) - 1;
  localparam longint AREA_MAX = (longint'(1) << AREA_W) - 1;

  logic CLK120 = 1'b0;
  logic RESET;

  always #4 CLK120 = ~CLK120;

  shwr_integral_multi_if #(.NCH(NCH), .ADC_W(ADC_W), .EXTRA_BITS(EXTRA_BITS), .AREA_W(AREA_W)) bus ();

  shwr_integral_multi #(
    .NCH(NCH), .ADC_W(ADC_W), .FRAC_W(FRAC_W), .EXTRA_BITS(EXTRA_BITS), .AREA_W(AREA_W),
    .PRE_DLY(PD), .SAT_LEVEL(SAT_LEVEL), .BL_INIT(BL_INIT)
  ) dut (
    .CLK120(CLK120),
    .RESET (RESET),
    .bus   (bus)
  );

  // Stimulus for the next edge
  int adc_in [NCH];
  bit trig_in;
  int win_in;

  // Reference model: raw sample history plus the expected registered outputs
  int     hist [NCH][HMAX];
  int     ecnt, e0;
  int     lb_m [NCH], base_m [NCH], fb_m [NCH], rb_m [NCH];
  int     phase, k_m, n_m;
  bit     prev_m, busy_m, done_m;
  longint int_m [NCH];
  int     peak_m [NCH];
  bit     sat_m [NCH];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s ch%0d observed=%0d expected=%0d", tag, c, obs, exp);
    end
  endtask

  function automatic int sample_at(input int c, input int idx);
    if (idx >= e0 && idx < HMAX) return hist[c][idx];
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      lb_m[c]   = BL_INIT << FRAC_W;
      base_m[c] = BL_INIT << EXTRA_BITS;
      int_m[c]  = 0;
      peak_m[c] = 0;
      sat_m[c]  = 1'b0;
    end
    phase  = 0;
    prev_m = 1'b1;
    busy_m = 1'b0;
    done_m = 1'b0;
    e0     = ecnt;
  endtask

  // Results of a window computed directly from the samples it covers.
  task automatic capture();
    for (int c = 0; c < NCH; c++) begin
      longint s  = 0;
      int     mx = 0;
      bit     st = 1'b0;
      for (int j = 0; j < n_m; j++) begin
        int v = sample_at(c, k_m - PD + j);
        s += longint'(v) * (1 << FRAC_W) - longint'(fb_m[c]);
        if (v > mx) mx = v;
        if (v >= SAT_LEVEL) st = 1'b1;
      end
      if (s < 0) int_m[c] = 0;
      else int_m[c] = ((s >>> FRAC_W) > AREA_MAX) ? AREA_MAX : (s >>> FRAC_W);
      peak_m[c] = (mx > rb_m[c]) ? mx - rb_m[c] : 0;
      sat_m[c]  = st;
    end
  endtask

  task automatic model_edge();
    int old [NCH];
    if (ecnt < HMAX) for (int c = 0; c < NCH; c++) hist[c][ecnt] = adc_in[c];
    done_m = 1'b0;
    case (phase)
      0: begin
        for (int c = 0; c < NCH; c++) begin
          int d = sample_at(c, ecnt - PD - 1) << FRAC_W;
          old[c]    = lb_m[c];
          base_m[c] = old[c] >> (FRAC_W - EXTRA_BITS);
          if (d > old[c] && old[c] < LB_MAX) lb_m[c] = old[c] + 1;
          else if (d < old[c] && old[c] > 0) lb_m[c] = old[c] - 1;
        end
        if (trig_in && !prev_m) begin
          phase = 1;
          k_m   = ecnt;
          n_m   = (win_in == 0) ? 1 : win_in;
          for (int c = 0; c < NCH; c++) begin
            fb_m[c] = old[c];
            rb_m[c] = (old[c] + (1 << (FRAC_W - 1))) >> FRAC_W;
          end
        end
      end
      1: if (ecnt == k_m + n_m) begin
        capture();
        done_m = 1'b1;
        phase  = 2;
      end
      default: if (!trig_in) phase = 0;
    endcase
    busy_m = (phase != 0);
    prev_m = trig_in;
    ecnt++;
  endtask

  task automatic check_outputs();
    chk("BUSY", 0, 32'(bus.BUSY), 32'(busy_m));
    chk("DONE", 0, 32'(bus.DONE), 32'(done_m));
    for (int c = 0; c < NCH; c++) begin
      chk("BASELINE", c, 32'(bus.BASELINE[c*BL_W +: BL_W]), 32'(base_m[c]));
      if (!busy_m || done_m) begin
        chk("INTEGRAL", c, 32'(bus.INTEGRAL[c*AREA_W +: AREA_W]), 32'(int_m[c]));
        chk("PEAK", c, 32'(bus.PEAK[c*ADC_W +: ADC_W]), 32'(peak_m[c]));
        chk("SATURATED", c, 32'(bus.SATURATED[c]), 32'(sat_m[c]));
      end
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) bus.ADC[c*ADC_W +: ADC_W] = ADC_W'(adc_in[c]);
    bus.TRIGGERED  = trig_in;
    bus.WINDOW_LEN = 12'(win_in);
  endtask

  task automatic tick();
    drive();
    @(posedge CLK120);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    drive();
    @(posedge CLK120);
    #1;
    RESET = 1'b0;
    model_reset();
    check_outputs();
  endtask

  task automatic set_all(input int v);
    for (int c = 0; c < NCH; c++) adc_in[c] = v;
  endtask

  initial begin
    int dcount;
    bit seen;
    ecnt = 0;
    trig_in = 1'b0;
    win_in = 10;
    set_all(BL_INIT);

    // 1: quiet input at the reset baseline
    do_reset();
    repeat (500) tick();
    for (int c = 0; c < NCH; c++) chk("T1_BASELINE", c, 32'(bus.BASELINE[c*BL_W +: BL_W]), 32'd1000);

    // 2: baseline ramps one LSB per cycle to a new level
    set_all(300);
    do_reset();
    repeat (3300) tick();
    for (int c = 0; c < NCH; c++) chk("T2_BASELINE", c, 32'(bus.BASELINE[c*BL_W +: BL_W]), 32'd1200);

    // 3: 5-sample pulse of 100 counts inside a 10-sample window
    set_all(BL_INIT);
    do_reset();
    repeat (30) tick();
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      set_all((i >= 3 && i <= 7) ? 350 : 250);
      trig_in = (i >= 5 && i < 8);
      tick();
      if (bus.DONE) begin
        dcount++;
        chk("T3_DONE_CYCLE", 0, 32'(i), 32'd15);
        for (int c = 0; c < NCH; c++) begin
          chk("T3_INTEGRAL", c, 32'(bus.INTEGRAL[c*AREA_W +: AREA_W]), 32'd500);
          chk("T3_PEAK", c, 32'(bus.PEAK[c*ADC_W +: ADC_W]), 32'd100);
          chk("T3_SAT", c, 32'(bus.SATURATED[c]), 32'd0);
        end
      end
    end
    chk("T3_DONE_COUNT", 0, 32'(dcount), 32'd1);

    // 4: full-scale channel clamps, below-baseline channel floors at zero
    adc_in[0] = 4095;
    adc_in[1] = 200;
    adc_in[2] = 0;
    trig_in = 1'b0;
    win_in = 4095;
    do_reset();
    repeat (8) tick();
    trig_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4200 && !seen; i++) begin
      adc_in[2] = $urandom_range(0, 4095);
      tick();
      if (bus.DONE) begin
        seen = 1'b1;
        chk("T4_INT0", 0, 32'(bus.INTEGRAL[0 +: AREA_W]), 32'd524287);
        chk("T4_SAT0", 0, 32'(bus.SATURATED[0]), 32'd1);
        chk("T4_INT1", 1, 32'(bus.INTEGRAL[AREA_W +: AREA_W]), 32'd0);
        chk("T4_PEAK1", 1, 32'(bus.PEAK[ADC_W +: ADC_W]), 32'd0);
        chk("T4_SAT1", 1, 32'(bus.SATURATED[1]), 32'd0);
      end
    end
    chk("T4_DONE_SEEN", 0, 32'(seen), 32'd1);
    trig_in = 1'b0;
    repeat (4) tick();

    // Random traffic: noisy baseline, occasional pulses, random triggers and windows
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++)
        adc_in[c] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4095)) : 240 + int'($urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) trig_in = ~trig_in;
      win_in = $urandom_range(0, 24);
      tick();
    end

    // 5: asynchronous reset in the middle of a window
    set_all(BL_INIT);
    trig_in = 1'b0;
    do_reset();
    repeat (20) tick();
    win_in = 50;
    trig_in = 1'b1;
    repeat (10) tick();
    #2;
    RESET = 1'b1;
    #1;
    chk("T5_BUSY", 0, 32'(bus.BUSY), 32'd0);
    chk("T5_DONE", 0, 32'(bus.DONE), 32'd0);
    for (int c = 0; c < NCH; c++) begin
      chk("T5_INTEGRAL", c, 32'(bus.INTEGRAL[c*AREA_W +: AREA_W]), 32'd0);
      chk("T5_BASELINE", c, 32'(bus.BASELINE[c*BL_W +: BL_W]), 32'd1000);
    end
    @(posedge CLK120);
    #1;
    RESET = 1'b0;
    model_reset();
    check_outputs();
    repeat (60) tick();
    trig_in = 1'b0;
    repeat (5) tick();

    // 6: long trigger level, zero window -> single one-sample capture, frozen baseline
    do_reset();
    repeat (20) tick();
    win_in = 0;
    trig_in = 1'b1;
    set_all(300);
    dcount = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.DONE) dcount++;
    end
    chk("T6_DONE_COUNT", 0, 32'(dcount), 32'd1);
    trig_in = 1'b0;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
